// File: rtl/register_file_mp_pkg.sv
// Shared types for the multi-port register file. Build option: REGISTER_FILE_BYPASS_EN
// enables same-cycle write-to-read forwarding.
package register_file_mp_pkg;
    localparam int rf_nregs_t = 32;
    localparam int RF_WIDTH   = 32;

    typedef logic [$clog2(rf_nregs_t)-1:0] regbits_t;
    typedef logic [RF_WIDTH-1:0]           word_t;
endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Busy scoreboard: a reserve sets a register busy, any write to it clears it.
// A reserve in the same cycle as a write wins, since it names a newer producer.
module rf_scoreboard #(
    parameter int NWRITE = 1,
    parameter int NREGS  = 32,
    parameter int SELW   = $clog2(NREGS),
    parameter int CNTW   = $clog2(NREGS) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWRITE-1:0]      wen,
    input  logic [NWRITE*SELW-1:0] wsel,
    input  logic                   rsv_en,
    input  logic [SELW-1:0]        rsv_sel,
    output logic [NREGS-1:0]       busy,
    output logic [CNTW-1:0]        busy_cnt
);
    logic [NREGS-1:0] busy_next;
    logic [CNTW-1:0]  cnt_next;
    logic             wr_hit;

    always_comb begin
        busy_next = busy;
        cnt_next  = '0;
        wr_hit    = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            wr_hit = 1'b0;
            for (int i = 0; i < NWRITE; i++)
                if (wen[i] && wsel[i*SELW +: SELW] == SELW'(r))
                    wr_hit = 1'b1;
            if (rsv_en && rsv_sel == SELW'(r))
                busy_next[r] = 1'b1;
            else if (wr_hit)
                busy_next[r] = 1'b0;
        end
        // r0 is hardwired zero and can never have an outstanding producer
        busy_next[0] = 1'b0;
        for (int r = 0; r < NREGS; r++)
            cnt_next = cnt_next + CNTW'(busy_next[r]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with busy scoreboard. Define REGISTER_FILE_BYPASS_EN
// to forward same-cycle write data (and clear rbusy) on matching read ports.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int NREGS  = rf_nregs_t,
    parameter int WIDTH  = RF_WIDTH,
    parameter int SELW   = $clog2(NREGS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*SELW-1:0]   wsel,
    input  logic [NWRITE*WIDTH-1:0]  wdat,
    input  logic [NREAD*SELW-1:0]    rsel,
    output logic [NREAD*WIDTH-1:0]   rdat,
    output logic [NREAD-1:0]         rbusy,
    input  logic                     rsv_en,
    input  logic [SELW-1:0]          rsv_sel,
    output logic [$clog2(NREGS):0]   busy_cnt
);
    localparam int CNTW = $clog2(NREGS) + 1;

    logic [NREGS-1:0][WIDTH-1:0]  regs;
    logic [NREGS-1:0]             busy;
    logic [NWRITE-1:0][SELW-1:0]  wsel_a;
    logic [NWRITE-1:0][WIDTH-1:0] wdat_a;

    for (genvar i = 0; i < NWRITE; i++) begin : g_wunpack
        assign wsel_a[i] = wsel[i*SELW +: SELW];
        assign wdat_a[i] = wdat[i*WIDTH +: WIDTH];
    end

    // Ascending port order makes the highest-index writer win a conflict
    always_ff @(posedge CLK) begin
        if (RST) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NWRITE; i++)
                if (wen[i] && wsel_a[i] != '0)
                    regs[wsel_a[i]] <= wdat_a[i];
        end
    end

    rf_scoreboard #(
        .NWRITE (NWRITE),
        .NREGS  (NREGS),
        .SELW   (SELW),
        .CNTW   (CNTW)
    ) u_sb (
        .clk      (CLK),
        .rst      (RST),
        .wen      (wen),
        .wsel     (wsel),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar j = 0; j < NREAD; j++) begin : g_rd
        logic [SELW-1:0]  sel;
        logic [WIDTH-1:0] rd;
        logic             rb;

        assign sel = rsel[j*SELW +: SELW];

        always_comb begin
            rd = regs[sel];
            rb = busy[sel];
`ifdef REGISTER_FILE_BYPASS_EN
            for (int i = 0; i < NWRITE; i++) begin
                if (wen[i] && wsel_a[i] == sel) begin
                    rd = wdat_a[i];
                    rb = 1'b0;
                end
            end
`endif
            if (sel == '0) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdat[j*WIDTH +: WIDTH] = rd;
        assign rbusy[j]               = rb;
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (NREAD=2, NWRITE=2, 32x32); follows
// REGISTER_FILE_BYPASS_EN for the same-cycle read expectation.
module tb_register_file_mp;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int NREGS  = 32;
    localparam int WIDTH  = 32;
    localparam int SELW   = 5;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NWRITE-1:0]       wen;
    logic [NWRITE*SELW-1:0]  wsel;
    logic [NWRITE*WIDTH-1:0] wdat;
    logic [NREAD*SELW-1:0]   rsel;
    logic [NREAD*WIDTH-1:0]  rdat;
    logic [NREAD-1:0]        rbusy;
    logic                    rsv_en;
    logic [SELW-1:0]         rsv_sel;
    logic [SELW:0]           busy_cnt;

    int checks = 0;
    int errors = 0;

    register_file_mp #(
        .NREAD (NREAD),
        .NWRITE(NWRITE),
        .NREGS (NREGS),
        .WIDTH (WIDTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wen      (wen),
        .wsel     (wsel),
        .wdat     (wdat),
        .rsel     (rsel),
        .rdat     (rdat),
        .rbusy    (rbusy),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .busy_cnt (busy_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RST = 1'b0; wen = '0; wsel = '0; wdat = '0; rsv_en = 1'b0; rsv_sel = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int port, input logic [SELW-1:0] r, input logic [31:0] d);
        wen[port]                = 1'b1;
        wsel[port*SELW +: SELW]  = r;
        wdat[port*WIDTH +: WIDTH] = d;
    endtask

    task automatic rd_sel(input logic [SELW-1:0] r0, input logic [SELW-1:0] r1);
        rsel = {r1, r0};
    endtask

    initial begin
        idle();
        rsel = '0;
        RST  = 1'b1;
        tick();
        idle();
        chk("reset_cnt", 32'(busy_cnt), 32'd0);

        // r5 written and reserved together: reserve wins
        wr(0, 5'd5, 32'hDEADBEEF);
        rsv_en = 1'b1; rsv_sel = 5'd5;
        rd_sel(5'd5, 5'd6);
        tick();
        idle();
        chk("r5_data", rdat[31:0], 32'hDEADBEEF);
        chk("r5_busy", 32'(rbusy[0]), 32'd1);
        chk("r5_cnt", 32'(busy_cnt), 32'd1);

        // reset overrides a concurrent write and reserve
        RST = 1'b1;
        wr(0, 5'd6, 32'h0000_1234);
        rsv_en = 1'b1; rsv_sel = 5'd8;
        tick();
        idle();
        chk("rst_r5", rdat[31:0], 32'd0);
        chk("rst_r6", rdat[63:32], 32'd0);
        chk("rst_rbusy", 32'(rbusy), 32'd0);
        chk("rst_cnt", 32'(busy_cnt), 32'd0);

        // r0: write and reserve are both discarded
        wr(0, 5'd0, 32'hFFFFFFFF);
        rsv_en = 1'b1; rsv_sel = 5'd0;
        rd_sel(5'd0, 5'd0);
        #1;
        chk("r0_comb", rdat[31:0], 32'd0);
        tick();
        idle();
        chk("r0_data", rdat[31:0], 32'd0);
        chk("r0_busy", 32'(rbusy[0]), 32'd0);
        chk("r0_cnt", 32'(busy_cnt), 32'd0);

        // latency: r7 holds 0x11, then 0x12345678 written
        wr(0, 5'd7, 32'h11);
        tick();
        idle();
        wr(0, 5'd7, 32'h12345678);
        rd_sel(5'd7, 5'd7);
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        chk("lat_same0", rdat[31:0], 32'h12345678);
        chk("lat_same1", rdat[63:32], 32'h12345678);
`else
        chk("lat_same0", rdat[31:0], 32'h11);
        chk("lat_same1", rdat[63:32], 32'h11);
`endif
        tick();
        idle();
        chk("lat_next0", rdat[31:0], 32'h12345678);
        chk("lat_next1", rdat[63:32], 32'h12345678);

        // write conflict: port1 wins
        wr(0, 5'd3, 32'hAAAA);
        wr(1, 5'd3, 32'hBBBB);
        rd_sel(5'd3, 5'd7);
        tick();
        idle();
        chk("conflict", rdat[31:0], 32'hBBBB);
        chk("conflict_other", rdat[63:32], 32'h12345678);

        // scoreboard on r9
        rsv_en = 1'b1; rsv_sel = 5'd9;
        rd_sel(5'd9, 5'd10);
        tick();
        idle();
        chk("sb_rsv_busy", 32'(rbusy[0]), 32'd1);
        chk("sb_rsv_cnt", 32'(busy_cnt), 32'd1);
        rsv_en = 1'b1; rsv_sel = 5'd9;
        wr(1, 5'd9, 32'h55);
        wr(0, 5'd10, 32'h77);
        tick();
        idle();
        chk("sb_both_busy", 32'(rbusy[0]), 32'd1);
        chk("sb_both_data", rdat[31:0], 32'h55);
        chk("sb_nonbusy_wr", 32'(rbusy[1]), 32'd0);
        chk("sb_both_cnt", 32'(busy_cnt), 32'd1);
        wr(0, 5'd9, 32'h66);
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        chk("sb_wr_comb", 32'(rbusy[0]), 32'd0);
`else
        chk("sb_wr_comb", 32'(rbusy[0]), 32'd1);
`endif
        tick();
        idle();
        chk("sb_clr_busy", 32'(rbusy[0]), 32'd0);
        chk("sb_clr_cnt", 32'(busy_cnt), 32'd0);
        chk("sb_clr_data", rdat[31:0], 32'h66);

        // fill the scoreboard
        for (int k = 1; k < NREGS; k++) begin
            rsv_en = 1'b1; rsv_sel = SELW'(k);
            tick();
            if (k == 16) chk("cnt_half", 32'(busy_cnt), 32'd16);
        end
        idle();
        rd_sel(5'd31, 5'd1);
        #1;
        chk("cnt_full", 32'(busy_cnt), 32'd31);
        chk("full_rbusy", 32'(rbusy), 32'd3);
        RST = 1'b1;
        tick();
        idle();
        chk("cnt_rst", 32'(busy_cnt), 32'd0);
        chk("cnt_rst_rbusy", 32'(rbusy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, dual-read register file.
- Configurable read/write port counts, register count and data width.
- Adds a per-register busy scoreboard (reserve at issue, clear at writeback) and optional write-to-read bypass.
- Sits in each core's decode stage; one instance per core in the multi-core datapath.

Parameters:
NREAD, 2, number of read ports (1..4)
NWRITE, 1, number of write ports (1..2)
NREGS, 32, number of architectural registers (power of two, >= 2)
WIDTH, 32, data word width in bits
SELW, $clog2(NREGS), register select width (derived; never overridden)

Ports:
CLK  in  1  core clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
wen  in  NWRITE  per-port write enable
wsel  in  NWRITE*SELW  packed write selects; port i at bits [i*SELW +: SELW]
wdat  in  NWRITE*WIDTH  packed write data; port i at bits [i*WIDTH +: WIDTH]
rsel  in  NREAD*SELW  packed read selects
rdat  out  NREAD*WIDTH  packed read data (combinational)
rbusy  out  NREAD  busy bit of register addressed by each rsel (combinational)
rsv_en  in  1  reserve request: mark rsv_sel busy
rsv_sel  in  SELW  register to reserve
busy_cnt  out  $clog2(NREGS)+1  number of registers currently busy (registered)

Behaviour:
- Reset: when RST=1 at a rising edge, all registers clear to 0, all busy bits clear, busy_cnt=0. Reset overrides every write and reserve in that cycle.
- Reset mid-operation: pending reservations are dropped. No write is committed in the reset cycle.
- Register 0:
  - Hardwired zero; writes to it are discarded.
  - Reads of it always return 0; rbusy for it is always 0.
  - Reserves of it are ignored.
- Write:
  - On a rising edge with wen[i]=1 and wsel[i]!=0, the register takes wdat[i].
  - Write latency is 1 cycle without bypass.
- Write conflict: if several ports write the same register in one cycle, the highest-index port wins. No error is flagged.
- Read:
  - rdat[j] = reg[rsel[j]] combinationally.
  - Reads are fully independent; any number of ports may select the same register.
- Scoreboard:
  - busy[r] is set on an edge where rsv_en=1 and rsv_sel=r.
  - busy[r] is cleared on an edge where any wen[i]=1 and wsel[i]=r.
- Scoreboard simultaneous events:
  - Reserve and write to the same register in one cycle: reserve wins, busy stays 1 (newer producer outstanding). The data write still commits.
  - Reserve of an already-busy register: stays busy. Write to a non-busy register: busy stays 0.
- busy_cnt: registered population count of the busy vector after the edge's updates; range 0..NREGS-1.
- Width rules:
  - Selects are unsigned.
  - When NREGS is a power of two, no out-of-range select exists.
  - Data is stored unmodified; no sign handling.

Optional Feature:
- Macro: REGISTER_FILE_BYPASS_EN.
- With the macro defined:
  - If wen[i]=1 and wsel[i]==rsel[j]!=0 in the same cycle, rdat[j]=wdat[i] (highest-index matching port).
  - rbusy[j] is forced to 0 in that case.
  - Effective read-after-write latency is 0 cycles.
- Without the macro: reads return the pre-edge register value; the new value is visible the cycle after the write. rbusy is unaffected by same-cycle writes.

Decomposition:
- cpu_types_pkg holds the shared types: add rf_nregs_t constant (32) and reuse regbits_t/word_t for the default configuration.
- Extend register_file_if with a parametrised interface carrying these ports; it gets rf and tb modports.
- One sub-module, rf_scoreboard: busy vector plus busy_cnt, with reserve/clear priority.
- The data array and read/bypass muxing stay in register_file_mp.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then RST=1 for one cycle -> rdat for r5 = 0, all rbusy=0, busy_cnt=0.
- r0 handling: wen=1, wsel=0, wdat=0xFFFFFFFF; rsv_en=1, rsv_sel=0 -> read r0 = 0, rbusy=0, busy_cnt=0.
- Write/read latency: write 0x12345678 to r7 at cycle N, rsel0=rsel1=7:
  - without bypass: read 0x12345678 from cycle N+1, old value during N.
  - with REGISTER_FILE_BYPASS_EN: read 0x12345678 during cycle N.
- Write conflict (NWRITE=2): port0 writes 0xAAAA to r3 and port1 writes 0xBBBB to r3 in the same cycle -> r3 = 0xBBBB.
- Scoreboard:
  - reserve r9 -> rbusy=1, busy_cnt=1.
  - then reserve r9 and write r9=0x55 in the same cycle -> busy stays 1, r9=0x55.
  - next write r9 alone -> busy=0, busy_cnt=0.
- Count: reserve r1..r31 over 31 cycles -> busy_cnt=31; then RST -> busy_cnt=0.
